// File: rtl/rv32i_types.sv
// Shared types and constants for the cache-line memory port responder.
package rv32i_types;

    localparam int LINE_BITS      = 256;
    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_BITS      = 32;

    // Responder sequencing: one backing-memory transaction in flight at a time
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LINE_RD = 2'd1,
        LINE_WR = 2'd2,
        DONE    = 2'd3
    } mem_resp_state_t;

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } mem_port_t;

    // Snapshot of the accepted request; byte offset bits are dropped on purpose
    typedef struct packed {
        mem_port_t   port;
        logic [29:0] wordAddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    // Pull one 32-bit word out of a line by word index
    function automatic logic [WORD_BITS-1:0] get_word(
        input logic [LINE_BITS-1:0] line,
        input logic [2:0]           idx
    );
        return line[32*idx +: 32];
    endfunction

endpackage

// File: rtl/line_word_merge.sv
// Combinational byte-granular merge of a store word into a cache line.
module line_word_merge
    import rv32i_types::*;
(
    input  logic [LINE_BITS-1:0] line_i,
    input  logic [31:0]          word_i,
    input  logic [2:0]           word_idx_i,
    input  logic [3:0]           wmask_i,
    output logic [LINE_BITS-1:0] line_o
);

    // Replace only the enabled bytes of the addressed word; everything else passes through
    always_comb begin
        line_o = line_i;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ((word_idx_i == 3'(w)) && wmask_i[b]) begin
                    line_o[w*32 + b*8 +: 8] = word_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_responder.sv
// Arbitrates instruction and data word ports onto a single line-wide backing
// memory, doing read-modify-write for stores.
module mem_port_responder
    import rv32i_types::*;
#(
    parameter bit DMEM_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          imem_addr,
    input  logic [3:0]           imem_rmask,
    output logic [31:0]          imem_rdata,
    output logic                 imem_resp,

    input  logic [31:0]          dmem_addr,
    input  logic [3:0]           dmem_rmask,
    input  logic [3:0]           dmem_wmask,
    input  logic [31:0]          dmem_wdata,
    output logic [31:0]          dmem_rdata,
    output logic                 dmem_resp,

    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    input  logic [LINE_BITS-1:0] bmem_rdata,
    output logic [LINE_BITS-1:0] bmem_wdata,
    input  logic                 bmem_resp
);

    mem_resp_state_t      state_q, state_d;
    mem_req_t             req_q, req_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic [31:0]          imem_rdata_q, imem_rdata_d;
    logic [31:0]          dmem_rdata_q, dmem_rdata_d;

    logic                 imemPending;
    logic                 dmemPending;
    logic                 pickDmem;
    logic [LINE_BITS-1:0] mergedLine;
    logic [31:0]          doneWord;
    logic                 unusedAddrBits;

    // Accesses are always word aligned, so the byte offset is deliberately dropped
    assign unusedAddrBits = ^{imem_addr[1:0], dmem_addr[1:0]};

    assign imemPending = |imem_rmask;
    assign dmemPending = (|dmem_rmask) | (|dmem_wmask);
    assign pickDmem    = dmemPending && (DMEM_FIRST || !imemPending);

    line_word_merge u_merge (
        .line_i     (line_q),
        .word_i     (req_q.wdata),
        .word_idx_i (req_q.wordAddr[2:0]),
        .wmask_i    (req_q.wmask),
        .line_o     (mergedLine)
    );

    // Returned word: straight from the arriving line on a load, from the latched pre-store line on a store
    assign doneWord = (state_q == LINE_RD) ? get_word(bmem_rdata, req_q.wordAddr[2:0])
                                           : get_word(line_q, req_q.wordAddr[2:0]);

    // Next-state logic: accept in IDLE, fetch line, optionally write it back, then complete
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        line_d       = line_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;

        case (state_q)
            IDLE: begin
                if (pickDmem) begin
                    req_d.port     = PORT_DMEM;
                    req_d.wordAddr = dmem_addr[31:2];
                    req_d.wmask    = dmem_wmask;
                    req_d.wdata    = dmem_wdata;
                    state_d        = LINE_RD;
                end else if (imemPending) begin
                    req_d.port     = PORT_IMEM;
                    req_d.wordAddr = imem_addr[31:2];
                    req_d.wmask    = 4'b0;
                    req_d.wdata    = 32'b0;
                    state_d        = LINE_RD;
                end
            end

            LINE_RD: begin
                if (bmem_resp) begin
                    line_d = bmem_rdata;
                    if (|req_q.wmask) begin
                        state_d = LINE_WR;
                    end else begin
                        state_d = DONE;
                        if (req_q.port == PORT_DMEM) begin
                            dmem_rdata_d = doneWord;
                        end else begin
                            imem_rdata_d = doneWord;
                        end
                    end
                end
            end

            LINE_WR: begin
                if (bmem_resp) begin
                    state_d = DONE;
                    if (req_q.port == PORT_DMEM) begin
                        dmem_rdata_d = doneWord;
                    end else begin
                        imem_rdata_d = doneWord;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            line_q       <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            line_q       <= line_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;
    assign imem_resp  = (state_q == DONE) && (req_q.port == PORT_IMEM);
    assign dmem_resp  = (state_q == DONE) && (req_q.port == PORT_DMEM);
    assign bmem_read  = (state_q == LINE_RD);
    assign bmem_write = (state_q == LINE_WR);
    assign bmem_addr  = (bmem_read || bmem_write) ? {req_q.wordAddr[29:3], 5'b0} : 32'b0;
    assign bmem_wdata = bmem_write ? mergedLine : '0;

endmodule

// File: tb/tb_mem_port_responder.sv
// Testbench for mem_port_responder: line memory model, per-port scoreboards,
// vector table plus directed corner-case sequences.
module tb_mem_port_responder;

    logic         clk;
    logic         rst;
    logic [31:0]  imem_addr;
    logic [3:0]   imem_rmask;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_rmask;
    logic [3:0]   dmem_wmask;
    logic [31:0]  dmem_wdata;
    logic [31:0]  dmem_rdata;
    logic         dmem_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [255:0] bmem_rdata;
    logic [255:0] bmem_wdata;
    logic         bmem_resp;

    int assertCount = 0;
    int failCount   = 0;
    int memDelay    = 1;
    int readHigh    = 0;

    logic [255:0] mem [logic [26:0]];
    logic [31:0]  imemQ[$];
    logic [31:0]  dmemQ[$];

    typedef struct {
        bit          isD;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic [31:0] expWord;
        int          expCycles;
    } vec_t;

    vec_t vecs[10];

    mem_port_responder #(.DMEM_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_rdata (bmem_rdata),
        .bmem_wdata (bmem_wdata),
        .bmem_resp  (bmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Untouched lines hold a recognisable per-word pattern derived from the address
    function automatic logic [255:0] defaultLine(input logic [26:0] idx);
        logic [255:0] l;
        logic [31:0]  a;
        for (int k = 0; k < 8; k++) begin
            a = {idx, 5'b0} + 32'(k * 4);
            l[k*32 +: 32] = 32'h5A00_0000 | (a & 32'h00FF_FFFC);
        end
        return l;
    endfunction

    function automatic logic [255:0] readLine(input logic [26:0] idx);
        if (mem.exists(idx)) return mem[idx];
        return defaultLine(idx);
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [255:0] l;
        l = readLine(addr[31:5]);
        return l[32*addr[4:2] +: 32];
    endfunction

    // Backing memory: answers memDelay cycles after it first sees a request
    initial begin
        int cnt;
        cnt = 0;
        bmem_resp  = 1'b0;
        bmem_rdata = {8{32'hBADB_AD00}};
        forever begin
            @(posedge clk);
            #1;
            bmem_resp  = 1'b0;
            bmem_rdata = {8{32'hBADB_AD00}};
            if (!rst) begin
                cnt = 0;
            end else if (bmem_read || bmem_write) begin
                if (cnt == memDelay) begin
                    cnt = 0;
                    checkOutput("bmem_addr line aligned", 256'(bmem_addr[4:0]), 256'd0);
                    checkOutput("bmem read/write exclusive", 256'(bmem_read && bmem_write), 256'd0);
                    if (bmem_read) bmem_rdata = readLine(bmem_addr[31:5]);
                    if (bmem_write) mem[bmem_addr[31:5]] = bmem_wdata;
                    bmem_resp = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response monitor: pops per-port scoreboards and checks the idle port holds its data
    initial begin
        logic [31:0] lastImem;
        logic [31:0] lastDmem;
        logic [31:0] prevAddr;
        logic        prevRead;
        logic [31:0] exp;
        lastImem = 32'b0;
        lastDmem = 32'b0;
        prevAddr = 32'b0;
        prevRead = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                lastImem = 32'b0;
                lastDmem = 32'b0;
                prevRead = 1'b0;
            end else begin
                if (imem_resp) begin
                    checkOutput("dmem_resp quiet while imem served", 256'(dmem_resp), 256'd0);
                    checkOutput("dmem_rdata held", 256'(dmem_rdata), 256'(lastDmem));
                    if (imemQ.size() == 0) begin
                        checkOutput("imem unexpected resp", 256'd1, 256'd0);
                    end else begin
                        exp = imemQ.pop_front();
                        checkOutput("imem_rdata", 256'(imem_rdata), 256'(exp));
                        lastImem = exp;
                    end
                end
                if (dmem_resp) begin
                    checkOutput("imem_rdata held", 256'(imem_rdata), 256'(lastImem));
                    if (dmemQ.size() == 0) begin
                        checkOutput("dmem unexpected resp", 256'd1, 256'd0);
                    end else begin
                        exp = dmemQ.pop_front();
                        checkOutput("dmem_rdata", 256'(dmem_rdata), 256'(exp));
                        lastDmem = exp;
                    end
                end
                if (bmem_read) begin
                    readHigh++;
                    if (prevRead) checkOutput("bmem_addr stable during read", 256'(bmem_addr), 256'(prevAddr));
                end
                prevRead = bmem_read;
                prevAddr = bmem_addr;
            end
        end
    end

    // Drive one port request, hold it until its resp, then release it; returns negedges until resp
    task automatic applyStimulus(input bit isD, input logic [31:0] addr, input logic [3:0] rmask,
                                 input logic [3:0] wmask, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, output int cycles);
        bit got;
        if (isD) begin
            dmem_addr  = addr;
            dmem_rmask = rmask;
            dmem_wmask = wmask;
            dmem_wdata = wdata;
            dmemQ.push_back(expRdata);
        end else begin
            imem_addr  = addr;
            imem_rmask = rmask;
            imemQ.push_back(expRdata);
        end
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 60) begin
            @(negedge clk);
            cycles++;
            got = isD ? dmem_resp : imem_resp;
        end
        checkOutput(isD ? "dmem resp arrived" : "imem resp arrived", 256'(got), 256'd1);
        @(posedge clk);
        #1;
        if (isD) begin
            dmem_rmask = 4'b0;
            dmem_wmask = 4'b0;
        end else begin
            imem_rmask = 4'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int dCycles;
        int iCycles;
        int g;
        bit seen;
        logic [255:0] l;

        vecs[0] = '{1'b0, 32'h0000_1004, 4'hF, 4'h0, 32'h0,          32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
        vecs[1] = '{1'b1, 32'h0000_2008, 4'h0, 4'h3, 32'h1234_5678,  32'hAAAA_AAAA, 32'hAAAA_5678, 6};
        vecs[2] = '{1'b1, 32'h0000_2009, 4'hF, 4'h0, 32'h0,          32'hAAAA_5678, 32'hAAAA_5678, 4};
        vecs[3] = '{1'b1, 32'h0000_3010, 4'h0, 4'hC, 32'hCAFE_F00D,  32'h5A00_3010, 32'hCAFE_3010, 6};
        vecs[4] = '{1'b1, 32'h0000_3014, 4'hF, 4'h9, 32'h1122_3344,  32'h5A00_3014, 32'h1100_3044, 6};
        vecs[5] = '{1'b0, 32'h0000_3010, 4'h1, 4'h0, 32'h0,          32'hCAFE_3010, 32'hCAFE_3010, 4};
        vecs[6] = '{1'b1, 32'h0000_3016, 4'h2, 4'h0, 32'h0,          32'h1100_3044, 32'h1100_3044, 4};
        vecs[7] = '{1'b1, 32'h0000_101C, 4'h0, 4'hF, 32'h0BAD_C0DE,  32'h5A00_101C, 32'h0BAD_C0DE, 6};
        vecs[8] = '{1'b0, 32'h0000_101E, 4'hF, 4'h0, 32'h0,          32'h0BAD_C0DE, 32'h0BAD_C0DE, 4};
        vecs[9] = '{1'b1, 32'h0000_1004, 4'h8, 4'h0, 32'h0,          32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};

        l = defaultLine(27'h80);
        l[63:32] = 32'hDEAD_BEEF;
        mem[27'h80] = l;
        l = defaultLine(27'h100);
        l[95:64] = 32'hAAAA_AAAA;
        mem[27'h100] = l;

        rst        = 1'b0;
        imem_addr  = 32'h0;
        imem_rmask = 4'h0;
        dmem_addr  = 32'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;

        #1;
        checkOutput("reset imem_resp", 256'(imem_resp), 256'd0);
        checkOutput("reset dmem_resp", 256'(dmem_resp), 256'd0);
        checkOutput("reset imem_rdata", 256'(imem_rdata), 256'd0);
        checkOutput("reset dmem_rdata", 256'(dmem_rdata), 256'd0);
        checkOutput("reset bmem_read", 256'(bmem_read), 256'd0);
        checkOutput("reset bmem_write", 256'(bmem_write), 256'd0);
        checkOutput("reset bmem_addr", 256'(bmem_addr), 256'd0);
        checkOutput("reset bmem_wdata", bmem_wdata, 256'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle bmem_read", 256'(bmem_read), 256'd0);

        // Vector table: single-port loads, stores, mixed masks, ignored byte offsets
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].isD, vecs[i].addr, vecs[i].rmask, vecs[i].wmask,
                          vecs[i].wdata, vecs[i].expRdata, cycles);
            checkOutput($sformatf("vec%0d latency", i), 256'(cycles), 256'(vecs[i].expCycles));
            checkOutput($sformatf("vec%0d memory word", i), 256'(memWord(vecs[i].addr)), 256'(vecs[i].expWord));
            @(posedge clk);
            #1;
        end

        // Store to one word leaves the rest of the line untouched
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("line 0x2000 word%0d", k), 256'(memWord(32'h0000_2000 + 32'(k*4))),
                        256'((k == 2) ? 32'hAAAA_5678 : (32'h5A00_2000 | 32'(k*4))));
        end

        // Simultaneous requests: data port first, fetch right after, nothing lost
        fork
            applyStimulus(1'b1, 32'h0000_2008, 4'hF, 4'h0, 32'h0, 32'hAAAA_5678, dCycles);
            applyStimulus(1'b0, 32'h0000_1000, 4'hF, 4'h0, 32'h0, 32'h5A00_1000, iCycles);
        join
        checkOutput("simultaneous dmem latency", 256'(dCycles), 256'd4);
        checkOutput("simultaneous imem latency", 256'(iCycles), 256'd8);
        @(posedge clk);
        #1;

        // Slow backing memory: read stays asserted with a stable address
        memDelay = 9;
        readHigh = 0;
        applyStimulus(1'b1, 32'h0000_3018, 4'hF, 4'h0, 32'h0, 32'h5A00_3018, cycles);
        checkOutput("slow read latency", 256'(cycles), 256'd12);
        checkOutput("slow read bmem_read cycles", 256'(readHigh), 256'd10);
        memDelay = 1;
        @(posedge clk);
        #1;

        // Reset while writing the line back
        dmem_addr  = 32'h0000_3000;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'h7777_7777;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bmem_write;
        end
        checkOutput("reached line write", 256'(seen), 256'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid-write reset bmem_write", 256'(bmem_write), 256'd0);
        checkOutput("mid-write reset bmem_read", 256'(bmem_read), 256'd0);
        checkOutput("mid-write reset bmem_addr", 256'(bmem_addr), 256'd0);
        checkOutput("mid-write reset bmem_wdata", bmem_wdata, 256'd0);
        checkOutput("mid-write reset dmem_resp", 256'(dmem_resp), 256'd0);
        checkOutput("mid-write reset dmem_rdata", 256'(dmem_rdata), 256'd0);
        dmem_wmask = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("no dmem_resp in reset", 256'(dmem_resp), 256'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("aborted store not written", 256'(memWord(32'h0000_3000)), 256'h5A00_3000);
        applyStimulus(1'b1, 32'h0000_3000, 4'hF, 4'h0, 32'h0, 32'h5A00_3000, cycles);
        checkOutput("post-reset load latency", 256'(cycles), 256'd4);
        @(posedge clk);
        #1;

        // Mask held one cycle past resp becomes a second request
        dmemQ.push_back(32'hDEAD_BEEF);
        dmemQ.push_back(32'hDEAD_BEEF);
        dmem_addr  = 32'h0000_1004;
        dmem_rmask = 4'hF;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 60) begin
            @(negedge clk);
            cycles++;
            seen = dmem_resp;
        end
        checkOutput("back-to-back first latency", 256'(cycles), 256'd4);
        @(negedge clk);
        checkOutput("back-to-back resp one cycle", 256'(dmem_resp), 256'd0);
        g = 1;
        @(posedge clk);
        #1;
        dmem_rmask = 4'h0;
        seen = 1'b0;
        while (!seen && g < 30) begin
            @(negedge clk);
            g++;
            seen = dmem_resp;
        end
        checkOutput("back-to-back gap", 256'(g), 256'd4);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("imem scoreboard drained", 256'(imemQ.size()), 256'd0);
        checkOutput("dmem scoreboard drained", 256'(dmemQ.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_responder.md
MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

Interface
REQ-001 Parameter: DMEM_FIRST, default 1; 1 = dmem wins simultaneous requests, 0 = imem wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 imem_addr  input  32  instruction fetch byte address.
REQ-005 imem_rmask  input  4  fetch byte mask; nonzero = request pending, held stable until imem_resp.
REQ-006 imem_rdata  output  32  fetched word.
REQ-007 imem_resp  output  1  one-cycle completion pulse for fetch.
REQ-008 dmem_addr  input  32  load/store byte address.
REQ-009 dmem_rmask  input  4  load byte mask; held stable until dmem_resp.
REQ-010 dmem_wmask  input  4  store byte mask; held stable until dmem_resp.
REQ-011 dmem_wdata  input  32  store data, byte i in bits [8i+7:8i].
REQ-012 dmem_rdata  output  32  loaded word.
REQ-013 dmem_resp  output  1  one-cycle completion pulse for load/store.
REQ-014 bmem_addr  output  32  line address, bits [4:0] always 0.
REQ-015 bmem_read  output  1  line read request, held until bmem_resp.
REQ-016 bmem_write  output  1  line write request, held until bmem_resp.
REQ-017 bmem_rdata  input  256  returned line; word k in bits [32k+31:32k].
REQ-018 bmem_wdata  output  256  line to write.
REQ-019 bmem_resp  input  1  one-cycle completion of current bmem read/write.

Function
REQ-020 FSM states IDLE, LINE_RD, LINE_WR, DONE; exactly one bmem transaction outstanding at any time.
REQ-021 IDLE: request pending if port mask nonzero; if none, stay IDLE with bmem_read/bmem_write low.
REQ-022 IDLE with both ports pending: pick per DMEM_FIRST; latch port id, addr, masks, wdata; go LINE_RD next cycle.
REQ-023 LINE_RD: bmem_read=1, bmem_addr={addr[31:5],5'b0}; on bmem_resp latch line; go LINE_WR if latched wmask nonzero, else DONE.
REQ-024 LINE_WR: bmem_write=1, bmem_wdata=latched line with word addr[4:2] bytes replaced where wmask[i]=1; on bmem_resp go DONE.
REQ-025 DONE: pulse selected port's resp for exactly one cycle, rdata = pre-store word addr[4:2] of latched line (all 32 bits, regardless of mask); next state IDLE.
REQ-026 Non-selected port's resp stays 0; its rdata holds previous value.
REQ-027 Requests are only sampled in IDLE; a mask still high in the cycle after DONE is a new request.
REQ-028 addr[1:0] ignored; access always word-aligned.
REQ-029 dmem with rmask and wmask both nonzero: treated as store, rdata returns old word.
REQ-030 Latency (bmem_resp one cycle after request): load/fetch resp 3 cycles after IDLE acceptance edge; store 5 cycles.
REQ-031 Port input changes after acceptance have no effect on the in-flight transaction.

Reset
REQ-032 rst=0 forces state IDLE and all outputs 0 (resp, rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata) immediately, independent of clk.
REQ-033 Reset mid-transaction abandons it; no resp is issued; first accepted request after release starts fresh.

Structure
REQ-034 Shared rv32i_types package holds mem_resp_state_t enum and constants LINE_BITS=256, WORDS_PER_LINE=8.
REQ-035 One sub-module, line_word_merge: combinational byte merge of 32-bit word into 256-bit line by word index and wmask.

Verification
REQ-036 Fetch 0x0000_1004, rmask 4'hF, line word1=0xDEAD_BEEF -> one LINE_RD at 0x0000_1000, imem_rdata=0xDEADBEEF, imem_resp one cycle.
REQ-037 Store 0x0000_2008, wmask 4'b0011, wdata 0x1234_5678, old word 0xAAAA_AAAA -> LINE_WR word2=0xAAAA_5678, other words unchanged, dmem_resp once.
REQ-038 imem and dmem request same cycle, DMEM_FIRST=1 -> dmem served first, imem served next, no request lost.
REQ-039 bmem_resp delayed 10 cycles -> bmem_read held 10 cycles with stable addr; single resp afterward.
REQ-040 rst=0 during LINE_WR -> bmem_write drops asynchronously, no dmem_resp; after release, new load completes normally.
REQ-041 Back-to-back loads, mask held one cycle after resp -> treated as second request, two resp pulses, separated by >=1 IDLE cycle.
